// File: rtl/udp_tx_packetizer.sv
// Purpose : buffers 32-bit sample words and hands them to udp_top one packet at a time.
// Latency : tx_start rises 2 cycles after the write that completes a packet; tx_data is registered FWFT.
// Backpr. : s_ready drops only at full; udp_top paces reads with tx_data_req, and a stalled packet is flushed after TIMEOUT.
//
// Ports:
//   clk, rst                          single clock, asynchronous active-high reset
//   s_data/s_valid/s_ready            sample input, written when s_valid & s_ready
//   tx_start                          one-cycle pulse: a full packet is buffered
//   tx_data_req/tx_data               per-word pull strobe and current head word
//   tx_data_length/tx_total_length    constant UDP and IP length fields
//   fifo_level                        stored word count
//   pkt_count/drop_count/req_err      completed packets, timed-out packets, sticky stray-req flag
module udp_tx_packetizer #(
  parameter int WORDS_PER_PKT = 64,
  parameter int FIFO_DEPTH    = 256,
  parameter int MIN_GAP       = 16,
  parameter int TIMEOUT       = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx_start,
  input  logic                          tx_data_req,
  output logic [31:0]                   tx_data,
  output logic [15:0]                   tx_data_length,
  output logic [15:0]                   tx_total_length,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   pkt_count,
  output logic [15:0]                   drop_count,
  output logic                          req_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORDS_PER_PKT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(MIN_GAP + 1);

  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_PKT   = LW'(WORDS_PER_PKT);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_PKT - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(MIN_GAP - 1);

  typedef enum logic [2:0] {IDLE, START, SEND, FLUSH, GAP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            s_ready_q, s_ready_d;
  logic [31:0]     head_q, head_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [15:0]     pkt_q, pkt_d;
  logic [15:0]     drop_q, drop_d;
  logic            err_q, err_d;
  logic            push;
  logic            pop;
  logic [31:0]     mem [FIFO_DEPTH];

  // s_ready_q always mirrors (level_q != FIFO_DEPTH), so a pop in the same
  // cycle never opens the door for a write at full.
  assign push = s_valid & s_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    pkt_d   = pkt_q;
    drop_d  = drop_q;
    err_d   = err_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (level_q >= LVL_PKT) state_d = START;
      end
      START: begin
        cnt_d   = '0;
        timer_d = '0;
        state_d = SEND;
      end
      SEND: begin
        timer_d = timer_q + TW'(1);
        if (tx_data_req) begin
          pop   = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_WORD) begin
            pkt_d   = pkt_q + 16'd1;
            gap_d   = '0;
            state_d = GAP;
          end
        end
        // A completing req wins over a simultaneous timeout.
        if (state_d == SEND && timer_q == LAST_TICK) state_d = FLUSH;
      end
      FLUSH: begin
        // Discard the unread rest of the packet so the next one starts aligned.
        pop   = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_WORD) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) state_d = IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (tx_data_req && state_q != SEND) err_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
    s_ready_d = (level_d != LVL_FULL);

    // Next head: the incoming word bypasses the array when it lands in an
    // otherwise empty FIFO, since the array write is not visible until later.
    if (level_d == '0)                    head_d = '0;
    else if (push && level_q == LW'(pop)) head_d = s_data;
    else                                  head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      s_ready_q <= 1'b0;
      head_q    <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      pkt_q     <= '0;
      drop_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      s_ready_q <= s_ready_d;
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      pkt_q     <= pkt_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign tx_start        = (state_q == START);
  assign tx_data         = head_q;
  assign tx_data_length  = 16'(8 + 4 * WORDS_PER_PKT);
  assign tx_total_length = 16'(28 + 4 * WORDS_PER_PKT);
  assign fifo_level      = level_q;
  assign pkt_count       = pkt_q;
  assign drop_count      = drop_q;
  assign req_err         = err_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Purpose : self-checking bench for udp_tx_packetizer (4 words/packet, 16-deep FIFO).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpr. : writes honour s_ready; reqs are issued only while the packet is in SEND.
module tb_udp_tx_packetizer;

  localparam int WPP   = 4;
  localparam int DEPTH = 16;
  localparam int GAPC  = 2;
  localparam int TMO   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        tx_data_req = 1'b0;
  logic        s_ready;
  logic        tx_start;
  logic [31:0] tx_data;
  logic [15:0] tx_data_length;
  logic [15:0] tx_total_length;
  logic [4:0]  fifo_level;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic        req_err;

  udp_tx_packetizer #(
    .WORDS_PER_PKT(WPP), .FIFO_DEPTH(DEPTH), .MIN_GAP(GAPC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .tx_start(tx_start), .tx_data_req(tx_data_req), .tx_data(tx_data),
    .tx_data_length(tx_data_length), .tx_total_length(tx_total_length),
    .fifo_level(fifo_level), .pkt_count(pkt_count), .drop_count(drop_count),
    .req_err(req_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WPP-1:0][31:0] w;     // written in order, expected on tx_data in order
    logic [15:0]          pkts;  // pkt_count expected after this packet
  } vec_t;

  vec_t        tbl [3];
  logic [31:0] sb [$];
  logic [31:0] junk;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int starts_seen = 0;
  int starts_served = 0;
  int exp_pkt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endtask

  task automatic step();
    @(negedge clk);
    s_valid     = 1'b0;
    tx_data_req = 1'b0;
    cyc++;
    if (tx_start) starts_seen++;
  endtask

  task automatic push_word(input logic [31:0] d);
    int g = 0;
    step();
    while (!s_ready && g < 100) begin step(); g++; end
    if (!s_ready) fail("push_wait_s_ready");
    else begin
      s_valid = 1'b1;
      s_data  = d;
      sb.push_back(d);
    end
  endtask

  task automatic sb_check(input string name);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0x%0h but no word expected", name, tx_data);
    end else begin
      e = sb.pop_front();
      check(name, tx_data, e);
    end
  endtask

  task automatic wait_start(output bit ok);
    int g = 0;
    while (starts_seen == starts_served && g < 100) begin step(); g++; end
    ok = (starts_seen != starts_served);
    if (!ok) fail("wait_tx_start");
    else     starts_served++;
  endtask

  task automatic pull_packet(input string name);
    bit ok;
    wait_start(ok);
    if (ok) begin
      for (int k = 0; k < WPP; k++) begin
        step();
        tx_data_req = 1'b1;
        sb_check(name);
      end
      exp_pkt++;
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int g;
    int s0;
    int last_req;

    for (int k = 0; k < WPP; k++) begin
      tbl[0].w[k] = 32'h28292a2b + 32'(k);
      tbl[1].w[k] = 32'hDEAD_BE00 ^ (32'h0101_0101 << k);
    end
    tbl[2].w[0] = 32'hFFFF_FFFF;
    tbl[2].w[1] = 32'h0000_0000;
    tbl[2].w[2] = 32'hA5A5_A5A5;
    tbl[2].w[3] = 32'h5A5A_5A5A;
    tbl[0].pkts = 16'd1;
    tbl[1].pkts = 16'd2;
    tbl[2].pkts = 16'd3;

    // ---- reset values ----
    rst = 1'b1;
    repeat (3) step();
    check("rst_s_ready",    32'(s_ready), 32'd0);
    check("rst_tx_start",   32'(tx_start), 32'd0);
    check("rst_tx_data",    tx_data, 32'd0);
    check("rst_level",      32'(fifo_level), 32'd0);
    check("rst_pkt_count",  32'(pkt_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_req_err",    32'(req_err), 32'd0);
    check("udp_length",     32'(tx_data_length), 32'd24);
    check("ip_length",      32'(tx_total_length), 32'd44);
    rst = 1'b0;
    step();
    check("s_ready_after_rst", 32'(s_ready), 32'd1);

    // ---- table: write a packet, check start latency, pull back-to-back ----
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < WPP; k++) push_word(tbl[r].w[k]);
      step();
      check("tbl_start_early", 32'(tx_start), 32'd0);
      step();
      check("tbl_start_latency", 32'(tx_start), 32'd1);
      starts_served = starts_seen;
      for (int k = 0; k < WPP; k++) begin
        step();
        check("tbl_data", tx_data, tbl[r].w[k]);
        tx_data_req = 1'b1;
        junk = sb.pop_front();
      end
      exp_pkt++;
      step();
      check("tbl_pkt_count", 32'(pkt_count), 32'(tbl[r].pkts));
      check("tbl_level_empty", 32'(fifo_level), 32'd0);
      check("tbl_tx_data_empty", tx_data, 32'd0);
      repeat (4) step();
    end

    // ---- inter-packet gap with a second packet already buffered ----
    for (int k = 0; k < 2 * WPP; k++) push_word(32'h1000_0000 + 32'(k));
    pull_packet("gap_pkt0");
    last_req = cyc;
    s0 = starts_seen;
    g = 0;
    while (starts_seen == s0 && g < 50) begin step(); g++; end
    if (starts_seen == s0) fail("gap_next_start");
    else check("gap_spacing", 32'(cyc - last_req), 32'(GAPC + 2));
    pull_packet("gap_pkt1");
    step();
    check("gap_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    check("gap_level", 32'(fifo_level), 32'd0);
    repeat (4) step();

    // ---- fill to full, offered words at full, pop+push at full ----
    for (int k = 0; k < DEPTH; k++) push_word(32'hF000_0000 + 32'(k));
    step();
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    check("full_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_data  = 32'hBAD0_0001;
    step();
    check("full_hold_level", 32'(fifo_level), 32'(DEPTH));
    s_valid = 1'b1;
    s_data  = 32'hBAD0_0002;
    step();
    check("full_hold_s_ready", 32'(s_ready), 32'd0);
    starts_served++;
    s_valid = 1'b1;
    s_data  = 32'hBAD0_0003;
    tx_data_req = 1'b1;
    sb_check("full_pop0");
    step();
    check("full_pop_level", 32'(fifo_level), 32'(DEPTH - 1));
    check("full_pop_s_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 32'hF000_0010;
    if (s_ready) sb.push_back(s_data);
    tx_data_req = 1'b1;
    sb_check("full_pop1");
    step();
    check("pushpop_level", 32'(fifo_level), 32'(DEPTH - 1));
    s_valid = 1'b1;
    s_data  = 32'hF000_0011;
    if (s_ready) sb.push_back(s_data);
    step();
    check("refill_level", 32'(fifo_level), 32'(DEPTH));
    check("refill_s_ready", 32'(s_ready), 32'd0);
    step();
    tx_data_req = 1'b1;
    sb_check("full_pop2");
    step();
    tx_data_req = 1'b1;
    sb_check("full_pop3");
    exp_pkt++;
    step();
    check("full_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    check("full_level_after", 32'(fifo_level), 32'(DEPTH - 2));
    push_word(32'hF000_0012);
    push_word(32'hF000_0013);
    repeat (4) pull_packet("full_drain");
    step();
    check("full_drain_level", 32'(fifo_level), 32'd0);
    check("full_drain_pkts", 32'(pkt_count), 32'(exp_pkt));
    repeat (4) step();

    // ---- timeout: one req then silence ----
    for (int k = 0; k < WPP; k++) push_word(32'h7000_0000 + 32'(k));
    wait_start(ok);
    step();
    tx_data_req = 1'b1;
    sb_check("tmo_first");
    repeat (TMO - 1) step();
    check("tmo_level_before", 32'(fifo_level), 32'd3);
    step();
    step();
    check("tmo_level_flushing", 32'(fifo_level), 32'd2);
    repeat (10) step();
    for (int k = 0; k < WPP - 1; k++) junk = sb.pop_front();
    check("tmo_drop_count", 32'(drop_count), 32'd1);
    check("tmo_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    check("tmo_level", 32'(fifo_level), 32'd0);
    check("tmo_req_err_clear", 32'(req_err), 32'd0);
    for (int k = 0; k < WPP; k++) push_word(32'h7100_0000 + 32'(k));
    pull_packet("tmo_next_pkt");
    step();
    check("tmo_next_pkt_count", 32'(pkt_count), 32'(exp_pkt));
    repeat (4) step();

    // ---- stray req in IDLE ----
    push_word(32'hA000_0000);
    push_word(32'hA000_0001);
    step();
    check("idle_level", 32'(fifo_level), 32'd2);
    check("idle_head", tx_data, 32'hA000_0000);
    tx_data_req = 1'b1;
    step();
    step();
    check("idle_req_err", 32'(req_err), 32'd1);
    check("idle_req_level", 32'(fifo_level), 32'd2);
    check("idle_req_head", tx_data, 32'hA000_0000);

    // ---- reset in the middle of SEND ----
    push_word(32'hA000_0002);
    push_word(32'hA000_0003);
    wait_start(ok);
    step();
    tx_data_req = 1'b1;
    sb_check("abort_pop0");
    step();
    tx_data_req = 1'b1;
    sb_check("abort_pop1");
    step();
    rst = 1'b1;
    #1;
    check("abort_level", 32'(fifo_level), 32'd0);
    check("abort_tx_data", tx_data, 32'd0);
    check("abort_pkt_count", 32'(pkt_count), 32'd0);
    check("abort_drop_count", 32'(drop_count), 32'd0);
    check("abort_req_err", 32'(req_err), 32'd0);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    sb.delete();
    exp_pkt = 0;
    s0 = starts_seen;
    starts_served = starts_seen;
    repeat (10) step();
    check("abort_no_start", 32'(starts_seen - s0), 32'd0);
    check("abort_level_after", 32'(fifo_level), 32'd0);

    // ---- random traffic, 1000 packets ----
    begin
      int pk_done = 0;
      int words_w = 0;
      int cnt = 0;
      int idle = 0;
      bit in_send = 1'b0;
      g = 0;
      while (pk_done < 1000 && g < 60000) begin
        step();
        g++;
        if (tx_start) begin
          in_send = 1'b1;
          cnt = 0;
          idle = 0;
        end else if (in_send) begin
          if ($urandom_range(0, 1) == 1 || idle >= 3) begin
            tx_data_req = 1'b1;
            sb_check("rand_data");
            cnt++;
            idle = 0;
            if (cnt == WPP) begin
              in_send = 1'b0;
              pk_done++;
            end
          end else begin
            idle++;
          end
        end
        if (words_w < 1000 * WPP && s_ready && $urandom_range(0, 3) != 0) begin
          s_valid = 1'b1;
          s_data  = $urandom;
          sb.push_back(s_data);
          words_w++;
        end
      end
      if (pk_done < 1000) fail("rand_packets");
      exp_pkt = pk_done;
    end
    repeat (3) step();
    check("rand_pkt_count", 32'(pkt_count), 32'(exp_pkt % 65536));
    check("rand_drop_count", 32'(drop_count), 32'd0);
    check("rand_level", 32'(fifo_level), 32'd0);
    check("rand_sb_empty", 32'(sb.size()), 32'd0);
    check("rand_req_err", 32'(req_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
